mem_arbiter_2p: RTL and testbench
=================================

# mem_arbiter_2p

Two-port round-robin arbiter that shares the single-ported `memory_256x8` (synchronous write, combinational read) between two requesters: port 0 (instruction fetch) and port 1 (data load/store) of the 8-bit CPU. It drives the memory's `we`/`addr`/`d_i` from the granted requester and registers `d_o` into that requester's read-data register. Each requester uses a valid/ack handshake. An optional lock keeps ownership across read-modify-write sequences, with a bounded lock length so the other port is never starved.

## Interface
- `DATA_W`, 8, data width; must match memory
- `ADDR_W`, 8, address width; must match memory
- `LOCK_MAX`, 4, maximum consecutive lock-extended grants to one port (≥1)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  transaction request per port
- `we0`, `we1`  in  1  1 = write, 0 = read
- `lock0`, `lock1`  in  1  request to keep ownership after this transaction
- `addr0`, `addr1`  in  ADDR_W  transaction address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `ack0`, `ack1`  out  1  transaction completes at the edge where `reqN && ackN`
- `rdata0`, `rdata1`  out  DATA_W  registered read data
- `busy`  out  1  high while in SERVE
- `mem_we`  out  1  to memory `we`
- `mem_addr`  out  ADDR_W  to memory `addr`
- `mem_d_i`  out  DATA_W  to memory `d_i`
- `mem_d_o`  in  DATA_W  from memory `d_o`

## Operation
- FSM states:
  - IDLE: no owner.
  - SERVE: registered `owner` ∈ {0,1}.
- Registers:
  - `prio`: port favoured on a tie.
  - `lock_cnt`: counts 0..LOCK_MAX.
- Arbitration function (used in IDLE, and in SERVE at completion):
  - Only one request high: grant it.
  - Both high: grant `prio`.
  - Neither high: go to IDLE.
- IDLE → SERVE(winner) at the edge where any `reqN` is high. `lock_cnt` ← 0.
- SERVE outputs (combinational from `owner`):
  - `ack[owner]` = 1; the other ack = 0.
  - `mem_we`/`mem_addr`/`mem_d_i` = `we`/`addr`/`wdata` of owner.
- Outside SERVE: `mem_we`=0, `mem_addr`=0, `mem_d_i`=0, both acks 0.
- Requester rule: hold `reqN`/`weN`/`addrN`/`wdataN`/`lockN` stable from assertion until the completing edge. A new command may be presented in the cycle after completion. Dropping `req` before ack is illegal (undefined).
- Completion edge in SERVE. The owner's `req` is high by protocol, so every SERVE cycle completes:
  - Read: `rdata[owner]` ← `mem_d_o`.
  - Write: the memory writes at this same edge; `rdata[owner]` is unchanged.
  - Lock continuation, if `lock[owner]`=1, `req[owner]` is still high at the sample, and `lock_cnt` < LOCK_MAX-1: stay SERVE(owner), `lock_cnt`++, `prio` unchanged.
  - Otherwise: `prio` ← other port, then arbitrate with the new `prio`, and `lock_cnt` ← 0.
- Back-to-back behaviour: when the other port is idle, the owner re-acquires every cycle, giving 1 transaction per cycle.
- A port's `lockN` is ignored unless that port is the owner.

## Timing
- Reset values: state=IDLE, `prio`=0, `lock_cnt`=0, `rdata0`=`rdata1`=0, `ack0`=`ack1`=0, `busy`=0, all `mem_*` outputs 0.
- Reset asserted mid-SERVE:
  - The completing edge is suppressed: no rdata update, state → IDLE.
  - The memory still sees `mem_we` from that cycle, so a write in flight may land.
- Latency:
  - `req` sampled high in IDLE → `ack` high in the next cycle.
  - Read data valid in `rdataN` the cycle after the ack cycle.
- Sustained throughput: 1 transaction/cycle. Under continuous contention, grants alternate 0,1,0,1.
- Lock bound: a locking port completes at most LOCK_MAX consecutive transactions while the other port is requesting.
- Read-after-write to the same address by consecutive transactions returns the new data (the write lands at the completing edge of the first).

## Test plan
- Reset, then `req0` read addr 0x00 with memory preloaded to 0xA5 → `ack0` high for 1 cycle, one cycle after the request; `rdata0`=0xA5; `mem_we` stays 0.
- Port 1 writes 0x5A @0x01, then reads @0x01 back-to-back → two consecutive `ack1` cycles; `rdata1`=0x5A after the second.
- Both ports request continuously (reads @0x00/@0x02 holding 0xA5/0xFF) from reset → acks alternate 0,1,0,1; `rdata0`=0xA5, `rdata1`=0xFF; no cycle with both acks high.
- Port 0 locked with LOCK_MAX=4 while port 1 requests → exactly 4 consecutive `ack0`, then `ack1`.
- `rst` asserted in a SERVE cycle of a port-1 read → next cycle `ack1`=0, `busy`=0, `rdata1`=0, `mem_addr`=0.
- Idle with no requests for 10 cycles → `busy`=0, `mem_we`=0 throughout, both rdata registers unchanged.

Source files
------------

// File: rtl/mem_arbiter_2p.sv
// Round-robin arbiter sharing one synchronous-write/combinational-read memory between
// an instruction-fetch port (0) and a data port (1), with a bounded ownership lock.
module mem_arbiter_2p #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d_i,
    input  logic [DATA_W-1:0] mem_d_o
);

    localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(LOCK_MAX - 1);

    typedef enum logic {StIdle, StServe} state_e;

    state_e            state_q;
    logic              owner_q;
    logic              prio_q;
    logic [CntW-1:0]   lock_cnt_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              serve;
    logic              own_req;
    logic              own_we;
    logic              own_lock;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    // Winner on a tie is the favoured port; otherwise whichever port requests.
    function automatic logic pick(input logic p, input logic r0, input logic r1);
        return (r0 && r1) ? p : r1;
    endfunction

    always_comb begin
        serve     = (state_q == StServe);
        own_req   = owner_q ? req1   : req0;
        own_we    = owner_q ? we1    : we0;
        own_lock  = owner_q ? lock1  : lock0;
        own_addr  = owner_q ? addr1  : addr0;
        own_wdata = owner_q ? wdata1 : wdata0;
    end

    // A granted cycle with the owner's request already withdrawn is not a transaction.
    assign ack0     = serve && !owner_q && req0;
    assign ack1     = serve && owner_q && req1;
    assign busy     = serve;
    assign mem_we   = serve && own_req && own_we;
    assign mem_addr = serve ? own_addr : '0;
    assign mem_d_i  = serve ? own_wdata : '0;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            lock_cnt_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        state_q    <= StServe;
                        owner_q    <= pick(prio_q, req0, req1);
                        lock_cnt_q <= '0;
                    end
                end
                StServe: begin
                    if (own_req && !own_we) begin
                        if (owner_q) rdata1_q <= mem_d_o;
                        else         rdata0_q <= mem_d_o;
                    end
                    if (own_req && own_lock && (lock_cnt_q < CntLast)) begin
                        lock_cnt_q <= lock_cnt_q + CntW'(1);
                    end else begin
                        prio_q     <= !owner_q;
                        lock_cnt_q <= '0;
                        if (req0 || req1) owner_q <= pick(!owner_q, req0, req1);
                        else              state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Bench for mem_arbiter_2p: directed scenarios plus a randomized run, all checked every
// cycle against a transaction-level model of ownership, priority, lock runs and memory.
module tb_mem_arbiter_2p;

    localparam int unsigned LockMax = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       r [2];
    logic       w [2];
    logic       l [2];
    logic [7:0] a [2];
    logic [7:0] d [2];
    logic       ack0, ack1, busy, mem_we;
    logic [7:0] rdata0, rdata1, mem_addr, mem_d_i, mem_d_o;

    logic [7:0] mem   [256];
    logic [7:0] m_mem [256];
    logic [7:0] m_rd  [2];
    int         m_owner, m_prio, m_run;
    bit         done  [2];
    bit         pend  [2];

    int checks = 0;
    int errors = 0;

    logic       s_ack0, s_ack1, s_busy, s_we;
    logic [7:0] s_addr, s_di, s_rd0, s_rd1;

    always #5 clk = ~clk;

    assign mem_d_o = mem[mem_addr];

    mem_arbiter_2p #(.DATA_W(8), .ADDR_W(8), .LOCK_MAX(LockMax)) dut (
        .clk(clk), .rst(rst),
        .req0(r[0]), .req1(r[1]), .we0(w[0]), .we1(w[1]),
        .lock0(l[0]), .lock1(l[1]), .addr0(a[0]), .addr1(a[1]),
        .wdata0(d[0]), .wdata1(d[1]),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_d_i(mem_d_i), .mem_d_o(mem_d_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input int p);
        if (r[0] && r[1]) return p;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_step();
        int o;
        o = m_owner;
        done[0] = 0;
        done[1] = 0;
        if (rst) begin
            if (o >= 0 && r[o] && w[o]) m_mem[a[o]] = d[o];
            m_owner = -1; m_prio = 0; m_run = 0;
            m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        end else if (o < 0) begin
            m_owner = winner(m_prio);
            m_run   = 0;
        end else begin
            if (r[o]) begin
                done[o] = 1;
                if (w[o]) m_mem[a[o]] = d[o];
                else      m_rd[o] = m_mem[a[o]];
            end
            if (r[o] && l[o] && (m_run + 1 < LockMax)) begin
                m_run++;
            end else begin
                m_prio  = 1 - o;
                m_owner = winner(m_prio);
                m_run   = 0;
            end
        end
    endtask

    // One clock: sample and compare at the falling edge, step the model, apply memory write.
    task automatic cycle();
        int         o;
        logic       wr;
        logic [7:0] wa, wd;
        @(negedge clk);
        s_ack0 = ack0; s_ack1 = ack1; s_busy = busy; s_we = mem_we;
        s_addr = mem_addr; s_di = mem_d_i; s_rd0 = rdata0; s_rd1 = rdata1;
        o = m_owner;
        check("ack0",   s_ack0, (o == 0) && r[0]);
        check("ack1",   s_ack1, (o == 1) && r[1]);
        check("busy",   s_busy, o >= 0);
        check("mem_we", s_we,   (o >= 0) ? (r[o] && w[o]) : 1'b0);
        check("mem_addr", s_addr, (o >= 0) ? a[o] : 8'h00);
        check("mem_d_i",  s_di,   (o >= 0) ? d[o] : 8'h00);
        check("rdata0", s_rd0, m_rd[0]);
        check("rdata1", s_rd1, m_rd[1]);
        wr = mem_we; wa = mem_addr; wd = mem_d_i;
        model_step();
        @(posedge clk);
        if (wr) mem[wa] <= wd;
        #1;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 2; p++) begin
            r[p] = 0; w[p] = 0; l[p] = 0; a[p] = 8'h00; d[p] = 8'h00;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic gen();
        for (int p = 0; p < 2; p++) begin
            if (done[p]) pend[p] = 0;
            if (!pend[p] && $urandom_range(0, 3) != 0) begin
                pend[p] = 1;
                w[p] = 1'($urandom_range(0, 1));
                a[p] = 8'($urandom_range(0, 7));
                d[p] = 8'($urandom);
                l[p] = ($urandom_range(0, 3) == 0);
            end
            r[p] = pend[p];
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'($urandom);
            m_mem[i] = mem[i];
        end
        mem[0] = 8'hA5; m_mem[0] = 8'hA5;
        mem[2] = 8'hFF; m_mem[2] = 8'hFF;
        m_owner = -1; m_prio = 0; m_run = 0;
        m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        pend[0] = 0; pend[1] = 0; done[0] = 0; done[1] = 0;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;
        cycle();
        check("reset_busy", s_busy, 1'b0);
        check("reset_rdata0", s_rd0, 8'h00);

        // Single read from port 0.
        r[0] = 1; a[0] = 8'h00;
        cycle();
        check("rd0_no_ack_yet", s_ack0, 1'b0);
        cycle();
        check("rd0_ack", s_ack0, 1'b1);
        check("rd0_we", s_we, 1'b0);
        r[0] = 0;
        cycle();
        check("rd0_ack_once", s_ack0, 1'b0);
        check("rd0_data", s_rd0, 8'hA5);
        cycle();

        // Port 1 write then read-back, back to back.
        r[1] = 1; w[1] = 1; a[1] = 8'h01; d[1] = 8'h5A;
        cycle();
        cycle();
        check("wr1_ack", s_ack1, 1'b1);
        check("wr1_we", s_we, 1'b1);
        w[1] = 0;
        cycle();
        check("rd1_ack", s_ack1, 1'b1);
        r[1] = 0;
        cycle();
        check("raw1_data", s_rd1, 8'h5A);
        cycle();

        // Continuous contention from reset: grants alternate starting with port 0.
        do_reset();
        r[0] = 1; a[0] = 8'h00; r[1] = 1; a[1] = 8'h02;
        for (int k = 0; k <= 8; k++) begin
            cycle();
            if (k > 0) begin
                check("alt_ack0", s_ack0, (k % 2) == 1);
                check("alt_ack1", s_ack1, (k % 2) == 0);
            end
        end
        check("alt_rdata0", s_rd0, 8'hA5);
        check("alt_rdata1", s_rd1, 8'hFF);
        clear_inputs();
        cycle();
        cycle();

        // Lock run bounded at LockMax while port 1 waits.
        do_reset();
        r[0] = 1; l[0] = 1; a[0] = 8'h00; r[1] = 1; a[1] = 8'h02;
        for (int k = 0; k <= 5; k++) begin
            cycle();
            if (k > 0) begin
                check("lock_ack0", s_ack0, k <= 4);
                check("lock_ack1", s_ack1, k == 5);
            end
        end
        clear_inputs();
        cycle();
        cycle();

        // Reset during a port-1 read.
        r[1] = 1; a[1] = 8'h02;
        cycle();
        rst = 1'b1;
        cycle();
        check("rst_serve_ack1", s_ack1, 1'b1);
        rst = 1'b0; r[1] = 0;
        cycle();
        check("rst_ack1", s_ack1, 1'b0);
        check("rst_busy", s_busy, 1'b0);
        check("rst_rdata1", s_rd1, 8'h00);
        check("rst_mem_addr", s_addr, 8'h00);

        // Ten idle cycles.
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("idle_busy", s_busy, 1'b0);
            check("idle_we", s_we, 1'b0);
            check("idle_rdata0", s_rd0, 8'h00);
            check("idle_rdata1", s_rd1, 8'h00);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            gen();
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        clear_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
